// File: rtl/adder_share_arbiter.sv
// ============================================================================
// adder_share_arbiter
// ----------------------------------------------------------------------------
// Purpose:
//   Shares one 32-bit adder among NREQ requesters, such as PC+4, branch
//   target and load/store address generation. A round-robin arbiter picks
//   one valid requester per cycle. The winner's a+b goes into a single-entry
//   output slot one cycle later. The slot is tagged with the requester index
//   and drained by a valid/ready consumer. The slot can drain and refill in
//   the same cycle, so the adder can produce one result every cycle.
//
// Parameters:
//   NREQ  number of requesters (2..8)
//   IDW   width of rsp_id, 2**IDW >= NREQ
//
// Ports:
//   clk        in   1        rising-edge clock
//   rst_n      in   1        synchronous reset, active-low
//   req_valid  in   NREQ     requester i presents valid operands
//   req_ready  out  NREQ     requester i accepted this cycle (one-hot or zero)
//   req_a      in   NREQ*32  operand A, requester i at [32*i+31:32*i]
//   req_b      in   NREQ*32  operand B, same packing
//   rsp_valid  out  1        output slot holds a result
//   rsp_ready  in   1        consumer takes the result this cycle
//   rsp_id     out  IDW      requester index that owns rsp_sum
//   rsp_sum    out  32       a+b modulo 2**32
//   rsp_carry  out  1        carry out of bit 31   (ADDER_ARB_FLAGS_EN only)
//   rsp_ovf    out  1        signed overflow       (ADDER_ARB_FLAGS_EN only)
//
// Configuration macro:
//   ADDER_ARB_FLAGS_EN  adds the registered rsp_carry / rsp_ovf outputs.
//                       When it is undefined the carry is discarded.
// ============================================================================
module adder_share_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*32-1:0]   req_a,
    input  logic [NREQ*32-1:0]   req_b,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
`ifdef ADDER_ARB_FLAGS_EN
    output logic                 rsp_carry,
    output logic                 rsp_ovf,
`endif
    output logic [31:0]          rsp_sum
);

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

    slot_state_t      state;
    logic [IDW-1:0]   ptr;
    logic             slot_free;
    logic             grant_found;
    logic [IDW-1:0]   grant_idx;
    logic [IDW-1:0]   ptr_next;
    int               scan_idx;
    int               next_idx;
    logic [31:0]      sel_a;
    logic [31:0]      sel_b;
`ifdef ADDER_ARB_FLAGS_EN
    logic [32:0]      sum_wide;
    logic             sum_ovf;
`else
    logic [31:0]      sum_wide;
`endif

    // The slot can take a new result when it is empty, or when the consumer
    // is draining it in this same cycle.
    always_comb begin
        slot_free = !rsp_valid || rsp_ready;
    end

    // Round-robin search. Start at ptr and walk upward, wrapping at NREQ-1.
    // The first valid requester found wins. The index arithmetic is done in
    // int so that a non-power-of-two NREQ still wraps correctly.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_idx    = 0;
        for (int k = 0; k < NREQ; k++) begin
            scan_idx = int'(ptr) + k;
            if (scan_idx >= NREQ) begin
                scan_idx = scan_idx - NREQ;
            end
            if (!grant_found && req_valid[scan_idx[IDW-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = scan_idx[IDW-1:0];
            end
        end
    end

    // Grants are issued only out of reset and only when the slot can take
    // the result. Gating with rst_n keeps every req_ready low during reset,
    // even though the slot registers only clear at the clock edge.
    always_comb begin
        req_ready = '0;
        if (rst_n && slot_free && grant_found) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    // The pointer moves to the requester after the winner, so the winner
    // gets the lowest priority on the next search.
    always_comb begin
        next_idx = int'(grant_idx) + 1;
        if (next_idx >= NREQ) begin
            next_idx = 0;
        end
        ptr_next = next_idx[IDW-1:0];
    end

    // Operand mux. The loop index is a constant, so each part-select is
    // static and compares against the winning index.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (int'(grant_idx) == i) begin
                sel_a = req_a[32*i +: 32];
                sel_b = req_b[32*i +: 32];
            end
        end
    end

    // The shared adder. When the flag outputs are built, the add is widened
    // to 33 bits so the carry out of bit 31 is available. Signed overflow
    // means both operands have the same sign and the sign of the result
    // differs from it.
`ifdef ADDER_ARB_FLAGS_EN
    always_comb begin
        sum_wide = {1'b0, sel_a} + {1'b0, sel_b};
        sum_ovf  = (sel_a[31] == sel_b[31]) && (sum_wide[31] != sel_a[31]);
    end
`else
    always_comb begin
        sum_wide = sel_a + sel_b;
    end
`endif

    // Slot FSM and all registered outputs.
    // EMPTY -> FULL when a request is granted.
    // FULL stays FULL while held, or when it drains and refills together.
    // FULL -> EMPTY on a drain without a new grant. rsp_id and rsp_sum keep
    // their last values after a drain.
    // On reset the slot contents are dropped and the pointer goes back to 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= SLOT_EMPTY;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_sum   <= '0;
            ptr       <= '0;
`ifdef ADDER_ARB_FLAGS_EN
            rsp_carry <= 1'b0;
            rsp_ovf   <= 1'b0;
`endif
        end else begin
            if (|req_ready) begin
                rsp_id  <= grant_idx;
                rsp_sum <= sum_wide[31:0];
                ptr     <= ptr_next;
`ifdef ADDER_ARB_FLAGS_EN
                rsp_carry <= sum_wide[32];
                rsp_ovf   <= sum_ovf;
`endif
            end
            case (state)
                SLOT_EMPTY: begin
                    if (|req_ready) begin
                        state     <= SLOT_FULL;
                        rsp_valid <= 1'b1;
                    end
                end
                SLOT_FULL: begin
                    if (rsp_ready && !(|req_ready)) begin
                        state     <= SLOT_EMPTY;
                        rsp_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= SLOT_EMPTY;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
